// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR delay scheduler.
// Contents:
//   LFSR_W           - width of the LFSR terminal counter and of every target
//   TIMEOUT_CYC_DFLT - default RUN-state watchdog limit in clocks
//   sched_state_e    - scheduler FSM state encoding
package lfsr_sched_pkg;

   localparam int unsigned LFSR_W           = 4;
   localparam int unsigned TIMEOUT_CYC_DFLT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      ACK  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req_i starting at index ptr_i and wrapping; the first set bit wins.
// Ports:
//   req_i   - request vector
//   ptr_i   - index with highest priority this cycle
//   gnt_o   - one-hot grant (all zero when no request)
//   idx_o   - binary index of the granted requester
//   valid_o - at least one request is present
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned IdxW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IdxW-1:0]  idx_o,
   output logic             valid_o
);

   int unsigned cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = (32'(ptr_i) + i) % N_REQ;
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IdxW'(cand);
         end
      end
   end

endmodule

// File: rtl/lfsr_delay_sched.sv
// Round-robin scheduler that shares one LFSR terminal counter among N_REQ requesters.
// Each request is one counter run to a per-requester target; the winner gets a one-cycle ack.
// Optional feature: define LFSR_SCHED_TIMEOUT_EN to add a RUN-state watchdog of TIMEOUT_CYC
// clocks that completes the service with ack_err=1 if lfsr_done never arrives.
// Ports:
//   clk_n         - clock, rising edge
//   rst           - asynchronous active-low reset
//   req           - per-requester request level
//   req_count     - per-requester target, slice i = [i*LFSR_W +: LFSR_W]
//   ack           - one-hot, one-cycle completion pulse
//   ack_err       - qualifies ack: zero target (or watchdog expiry)
//   busy          - high in every state except IDLE
//   lfsr_count_en - counter count enable (RUN only)
//   lfsr_count_to - counter terminal value, held between services
//   lfsr_load     - counter load strobe (LOAD only)
//   lfsr_done     - counter done, sampled only in RUN
module lfsr_delay_sched
   import lfsr_sched_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
   input  logic                      clk_n,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*LFSR_W-1:0]   req_count,
   output logic [N_REQ-1:0]          ack,
   output logic                      ack_err,
   output logic                      busy,
   output logic                      lfsr_count_en,
   output logic [LFSR_W-1:0]         lfsr_count_to,
   output logic                      lfsr_load,
   input  logic                      lfsr_done
);

   localparam int unsigned IdxW = $clog2(N_REQ);

   sched_state_e      state_q, state_d;
   logic [IdxW-1:0]   winner_q, winner_d;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [LFSR_W-1:0] count_to_q, count_to_d;
   logic              err_q, err_d;

   logic [N_REQ-1:0]  unused_arb_gnt;
   logic [IdxW-1:0]   arb_idx;
   logic              arb_valid;
   logic [LFSR_W-1:0] arb_tgt;
   logic              tmo_hit;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (unused_arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign arb_tgt = req_count[arb_idx*LFSR_W +: LFSR_W];

`ifdef LFSR_SCHED_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

   logic [TmoW-1:0] tmo_q, tmo_d;

   // tmo_q counts RUN cycles already completed; expiry on the TIMEOUT_CYC-th RUN cycle.
   assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == RUN) begin
         tmo_d = tmo_q + TmoW'(1);
      end else if (state_d == LOAD) begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clk_n or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_timeout;

   assign tmo_hit        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      ptr_d      = ptr_q;
      count_to_d = count_to_q;
      err_d      = err_q;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               winner_d   = arb_idx;
               count_to_d = arb_tgt;
               // Zero is never reached by the LFSR, so skip the counter entirely.
               if (arb_tgt == '0) begin
                  err_d   = 1'b1;
                  state_d = ACK;
               end else begin
                  err_d   = 1'b0;
                  state_d = LOAD;
               end
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (lfsr_done) begin
               state_d = ACK;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            ptr_d   = (winner_q == IdxW'(N_REQ - 1)) ? '0 : winner_q + IdxW'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_n or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         winner_q   <= '0;
         ptr_q      <= '0;
         count_to_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         ptr_q      <= ptr_d;
         count_to_q <= count_to_d;
         err_q      <= err_d;
      end
   end

   // Outputs decode straight from registered state so an async reset clears them at once.
   always_comb begin
      ack           = '0;
      ack_err       = 1'b0;
      busy          = (state_q != IDLE);
      lfsr_load     = (state_q == LOAD);
      lfsr_count_en = (state_q == RUN);
      lfsr_count_to = count_to_q;
      if (state_q == ACK) begin
         ack[winner_q] = 1'b1;
         ack_err       = err_q;
      end
   end

endmodule

// File: tb/tb_lfsr_delay_sched.sv
// Self-checking bench for lfsr_delay_sched (N_REQ=4, TIMEOUT_CYC=8).
// Table of single-service records plus hand sequences for reset mid-RUN and the watchdog.
module tb_lfsr_delay_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TMO  = 8;

   logic             clk_n;
   logic             rst;
   logic [NREQ-1:0]  req;
   logic [NREQ*4-1:0] req_count;
   logic [NREQ-1:0]  ack;
   logic             ack_err;
   logic             busy;
   logic             lfsr_count_en;
   logic [3:0]       lfsr_count_to;
   logic             lfsr_load;
   logic             lfsr_done;

   lfsr_delay_sched #(
      .N_REQ       (NREQ),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_n         (clk_n),
      .rst           (rst),
      .req           (req),
      .req_count     (req_count),
      .ack           (ack),
      .ack_err       (ack_err),
      .busy          (busy),
      .lfsr_count_en (lfsr_count_en),
      .lfsr_count_to (lfsr_count_to),
      .lfsr_load     (lfsr_load),
      .lfsr_done     (lfsr_done)
   );

   initial clk_n = 1'b0;
   always #5 clk_n = ~clk_n;

   // mode: 0 = pulse done on RUN cycle 'run', 1 = done held high, 2 = done never
   typedef struct {
      logic [3:0]  req;
      logic [15:0] cnt;
      int          run;
      int          mode;
      int          exp_idx;
      logic        exp_err;
   } vec_t;

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE.
   task automatic run_vec(input vec_t v, input string name);
      int         k;
      int         loads;
      int         runs;
      logic       seen;
      logic       cto_ok;
      logic [3:0] tgt;
      int         exp_lat;
      req       = v.req;
      req_count = v.cnt;
      tgt       = v.cnt[v.exp_idx*4 +: 4];
      lfsr_done = (v.mode == 1);
      exp_lat   = (v.run == 0) ? 1 : v.run + 2;
      k = 0; loads = 0; runs = 0; seen = 1'b0; cto_ok = 1'b1;
      while (!seen && k < 60) begin
         @(negedge clk_n);
         k++;
         if (lfsr_load) loads++;
         if (lfsr_count_en) begin
            runs++;
            if (lfsr_count_to !== tgt) cto_ok = 1'b0;
         end
         if (ack !== '0) begin
            seen = 1'b1;
            check({name, " ack onehot"}, 32'(ack), 32'(1) << v.exp_idx);
            check({name, " ack_err"}, 32'(ack_err), 32'(v.exp_err));
            check({name, " latency"}, k, exp_lat);
         end else begin
            lfsr_done = (v.mode == 1) ||
                        (v.mode == 0 && lfsr_count_en && runs == v.run);
         end
      end
      lfsr_done = 1'b0;
      check({name, " ack seen"}, 32'(seen), 32'd1);
      check({name, " load pulses"}, loads, (v.run == 0) ? 0 : 1);
      check({name, " run cycles"}, runs, v.run);
      check({name, " count_to in RUN"}, 32'(cto_ok), 32'd1);
      @(negedge clk_n);
      check({name, " idle busy"}, 32'(busy), 32'd0);
      check({name, " ack one cycle"}, 32'(ack), 32'd0);
      check({name, " count_to held"}, 32'(lfsr_count_to), 32'(tgt));
   endtask

   vec_t vecs[12];

   initial begin
      int   runs;
      logic bad;

      vecs[0]  = '{4'b1111, 16'h5555, 1, 0, 0, 1'b0};
      vecs[1]  = '{4'b1111, 16'h5555, 2, 0, 1, 1'b0};
      vecs[2]  = '{4'b1111, 16'h5555, 3, 0, 2, 1'b0};
      vecs[3]  = '{4'b1111, 16'h5555, 1, 0, 3, 1'b0};
      vecs[4]  = '{4'b1111, 16'h5555, 2, 0, 0, 1'b0};
      vecs[5]  = '{4'b0001, 16'h000B, 6, 0, 0, 1'b0};
      vecs[6]  = '{4'b0100, 16'h0000, 0, 0, 2, 1'b1};
      vecs[7]  = '{4'b0011, 16'h0021, 3, 0, 0, 1'b0};
      vecs[8]  = '{4'b1010, 16'hC0D0, 2, 0, 1, 1'b0};
      vecs[9]  = '{4'b1001, 16'h4005, 4, 0, 3, 1'b0};
      vecs[10] = '{4'b1000, 16'hF000, 1, 1, 3, 1'b0};
      vecs[11] = '{4'b0110, 16'h0700, 0, 0, 1, 1'b1};

      rst = 1'b0; req = '0; req_count = '0; lfsr_done = 1'b0;
      repeat (2) @(negedge clk_n);
      check("reset ack", 32'(ack), 32'd0);
      check("reset ack_err", 32'(ack_err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset count_en", 32'(lfsr_count_en), 32'd0);
      check("reset count_to", 32'(lfsr_count_to), 32'd0);
      check("reset load", 32'(lfsr_load), 32'd0);
      rst = 1'b1;
      @(negedge clk_n);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset asserted mid-RUN, then the still-pending request is served again from LOAD.
      req = 4'b0100; req_count = 16'h0900; lfsr_done = 1'b0;
      runs = 0;
      for (int k = 0; k < 20 && runs < 2; k++) begin
         @(negedge clk_n);
         if (lfsr_count_en) runs++;
      end
      check("midrun reached RUN", runs, 2);
      rst = 1'b0;
      #1;
      check("midrun count_en", 32'(lfsr_count_en), 32'd0);
      check("midrun load", 32'(lfsr_load), 32'd0);
      check("midrun ack", 32'(ack), 32'd0);
      check("midrun busy", 32'(busy), 32'd0);
      @(negedge clk_n);
      check("midrun ack held", 32'(ack), 32'd0);
      rst = 1'b1;
      run_vec('{4'b0100, 16'h0900, 1, 0, 2, 1'b0}, "reserve");

      // Watchdog: done never arrives.
`ifdef LFSR_SCHED_TIMEOUT_EN
      run_vec('{4'b0001, 16'h0003, TMO, 2, 0, 1'b1}, "timeout");
`else
      req = 4'b0001; req_count = 16'h0003; lfsr_done = 1'b0;
      bad = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_n);
         if (ack !== '0 || busy !== 1'b1) bad = 1'b1;
         if (k >= 2 && lfsr_count_en !== 1'b1) bad = 1'b1;
      end
      check("no timeout stall", 32'(bad), 32'd0);
      rst = 1'b0;
      @(negedge clk_n);
      rst = 1'b1;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lfsr_delay_sched.md
Name: lfsr_delay_sched

Overview:
- Round-robin scheduler sharing one 4-bit LFSR terminal counter (count_en / count_to / load / done) among N_REQ requesters.
- Each requester asks for one LFSR run to a 4-bit target.
- The block arbitrates, loads the target, enables counting, waits for done, then acks the winner.
- Sits between the LFSR counter and the timing/delay clients in the datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LFSR_W, 4, LFSR / target width; fixed to match the counter.
- TIMEOUT_CYC, 32, watchdog limit in clocks; used only with LFSR_SCHED_TIMEOUT_EN.

Ports:
- clk_n  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- req_count  in  N_REQ*LFSR_W  per-requester target; slice i = [i*LFSR_W +: LFSR_W].
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- ack_err  out  1  qualifies ack: request completed abnormally.
- busy  out  1  high in every state except IDLE.
- lfsr_count_en  out  1  drives counter count_en.
- lfsr_count_to  out  LFSR_W  drives counter count_to.
- lfsr_load  out  1  drives counter load.
- lfsr_done  in  1  counter done.

Behaviour:
- Reset (rst=0, async): state=IDLE; ack=0, ack_err=0, busy=0, lfsr_count_en=0, lfsr_count_to=0, lfsr_load=0; RR pointer=0.
- Requester rule: hold req high and req_count stable until its ack pulse. Drop req the cycle after ack, or keep it high to request again.
- FSM states: IDLE, LOAD, RUN, ACK.
- IDLE:
  - If any req is high, pick the winner round-robin, starting at the RR pointer.
  - Latch winner id and req_count[winner] into lfsr_count_to.
  - If the target is 0, go to ACK with ack_err=1. Zero is not reachable by the LFSR, so the counter is not used.
  - Otherwise go to LOAD.
- LOAD: lfsr_load=1 for exactly one cycle; count_en=0. Next state RUN.
- RUN:
  - lfsr_count_en=1 and lfsr_count_to held stable.
  - The first cycle lfsr_done is sampled high moves to ACK.
  - lfsr_done is ignored outside RUN.
- ACK:
  - ack[winner]=1 for one cycle; ack_err as set.
  - lfsr_count_en=0 and lfsr_load=0.
  - RR pointer = winner+1, wrapping at N_REQ-1 to 0.
  - Next state IDLE.
- Latency:
  - Grant to load is 1 cycle.
  - Minimum request-to-ack is 4 cycles (IDLE, LOAD, RUN with done already high, ACK).
  - At least one IDLE cycle between services; no back-to-back reuse.
- Arbitration is fair: a continuously requesting client waits at most N_REQ-1 services.
- If req drops mid-service, the service completes and ack is still pulsed; the requester ignores it.
- Simultaneous requests: only the RR winner is served; the rest stay pending.
- Reset mid-RUN: outputs go immediately to reset values; no ack is issued for the aborted service.
- lfsr_count_to keeps its last value in IDLE (no glitching toward the counter).

Optional Feature:
- Macro: LFSR_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN.
  - If lfsr_done has not been seen after TIMEOUT_CYC RUN cycles, go to ACK with ack_err=1.
  - The counter clears on entry to LOAD.
- Undefined:
  - No counter is present; RUN waits indefinitely.
  - ack_err is asserted only for a zero target.

Decomposition:
- Package lfsr_sched_pkg holds:
  - LFSR_W constant;
  - state enum sched_state_e {IDLE, LOAD, RUN, ACK};
  - TIMEOUT_CYC default.
- One sub-module, rr_arbiter:
  - inputs: req vector and pointer;
  - outputs: one-hot grant and binary index;
  - purely combinational.

Test Plan:
- Single request: req[0]=1, count=4'b1011, done after 6 RUN cycles. Required: one load pulse, count_to=1011 through RUN, ack[0] exactly one cycle after done sampled, ack_err=0.
- Contention: req=4'b1111 held, all counts=4'b0101, pointer=0. Required: acks in order 0,1,2,3,0; busy low exactly one cycle between services.
- Zero target: req[2]=1, count=0. Required: no lfsr_load, no count_en, ack[2] with ack_err=1 two cycles after req.
- Reset mid-RUN: assert rst=0 during RUN. Required: count_en/load/ack drop immediately; after release, a pending req is re-served from LOAD.
- Timeout (macro defined, TIMEOUT_CYC=8): done held 0. Required: ack with ack_err=1 after 8 RUN cycles. Macro undefined: busy stays high and no ack.
